// File: rtl/bp_pkg.sv
// Shared constants, counter ops and helpers for the branch predictor.
// Optional statistics counters are built with BP_STATS_EN.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    CTR_HOLD,
    CTR_INC,
    CTR_DEC,
    CTR_MAX
  } ctr_op_e;

  function automatic int unsigned ctr_weak_taken(
    input int unsigned bits
  );
    return 32'd1 << (bits - 1);
  endfunction

  function automatic int unsigned ctr_weak_ntaken(
    input int unsigned bits
  );
    return ctr_weak_taken(bits) - 1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating counter next-value logic: inc, dec, set-max or hold.
// Purely combinational; used on the predictor table write path.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] i_ctr,
  input  ctr_op_e      i_op,
  output logic [W-1:0] o_next
);

  always_comb begin
    o_next = i_ctr;
    unique case (i_op)
      CTR_INC: if (i_ctr != '1) o_next = i_ctr + W'(1);
      CTR_DEC: if (i_ctr != '0) o_next = i_ctr - W'(1);
      CTR_MAX: o_next = '1;
      default: o_next = i_ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped counter table + BTB with EX resolution and redirect.
// Define BP_STATS_EN to build the hit/mispredict statistics counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH = 12,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = PC_WIDTH - 2 - IDX_W
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [PC_WIDTH-1:0] IF_PC,
  output logic                PRED_TAKEN,
  output logic [PC_WIDTH-1:0] PRED_TARGET,
  input  logic                EX_VALID,
  input  logic [PC_WIDTH-1:0] EX_PC,
  input  logic                EX_IS_BRANCH,
  input  logic                EX_IS_JUMP,
  input  logic                EX_TAKEN,
  input  logic [PC_WIDTH-1:0] EX_TARGET,
  input  logic                EX_PRED_TAKEN,
  input  logic [PC_WIDTH-1:0] EX_PRED_TARGET,
  output logic                MISPREDICT,
  output logic [PC_WIDTH-1:0] REDIRECT_PC,
  output logic [31:0]         STAT_HITS,
  output logic [31:0]         STAT_MISSES
);

  localparam logic [PC_WIDTH-1:0] LP_INC =
    PC_WIDTH'(PC_INC);
  localparam logic [CTR_BITS-1:0] LP_WT =
    CTR_BITS'(ctr_weak_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] LP_WNT =
    CTR_BITS'(ctr_weak_ntaken(CTR_BITS));

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_W-1:0]    r_tag [ENTRIES];
  logic [PC_WIDTH-1:0] r_tgt [ENTRIES];
  logic [CTR_BITS-1:0] r_ctr [ENTRIES];

  logic [IDX_W-1:0]    w_if_idx;
  logic [TAG_W-1:0]    w_if_tag;
  logic                w_if_hit;
  logic [IDX_W-1:0]    w_ex_idx;
  logic [TAG_W-1:0]    w_ex_tag;
  logic                w_ex_hit;
  logic                w_ctl;
  logic                w_act_taken;
  logic                w_resolve;
  logic                w_misp;
  logic                w_wr_en;
  logic                w_tgt_wr;
  ctr_op_e             w_op;
  logic [CTR_BITS-1:0] w_ctr_next;
  logic [CTR_BITS-1:0] w_ctr_wr;

  assign w_if_idx = IF_PC[2 +: IDX_W];
  assign w_if_tag = IF_PC[PC_WIDTH-1 -: TAG_W];
  assign w_if_hit = r_valid[w_if_idx] &
                    (r_tag[w_if_idx] == w_if_tag);

  assign PRED_TAKEN  = w_if_hit &
                       r_ctr[w_if_idx][CTR_BITS-1];
  assign PRED_TARGET = PRED_TAKEN ? r_tgt[w_if_idx]
                                  : IF_PC + LP_INC;

  assign w_ex_idx = EX_PC[2 +: IDX_W];
  assign w_ex_tag = EX_PC[PC_WIDTH-1 -: TAG_W];
  assign w_ex_hit = r_valid[w_ex_idx] &
                    (r_tag[w_ex_idx] == w_ex_tag);

  assign w_ctl       = EX_IS_BRANCH | EX_IS_JUMP;
  assign w_act_taken = EX_TAKEN & w_ctl;
  assign w_resolve   = EX_VALID & w_ctl;

  // Gated by RSTn so the flush logic stays quiet during reset.
  assign w_misp = RSTn & EX_VALID &
    ((w_act_taken != EX_PRED_TAKEN) |
     (EX_TAKEN & EX_PRED_TAKEN &
      (EX_TARGET != EX_PRED_TARGET)));

  assign MISPREDICT  = w_misp;
  assign REDIRECT_PC = w_act_taken ? EX_TARGET
                                   : EX_PC + LP_INC;

  assign w_wr_en  = w_resolve & (w_ex_hit | w_act_taken);
  assign w_tgt_wr = w_act_taken | EX_IS_JUMP;

  always_comb begin
    w_op = CTR_HOLD;
    unique case (1'b1)
      EX_IS_JUMP:                 w_op = CTR_MAX;
      !EX_IS_JUMP &  w_act_taken: w_op = CTR_INC;
      !EX_IS_JUMP & !w_act_taken: w_op = CTR_DEC;
      default:                    w_op = CTR_HOLD;
    endcase
  end

  bp_sat_counter #(
    .W (CTR_BITS)
  ) u_ctr (
    .i_ctr  (r_ctr[w_ex_idx]),
    .i_op   (w_op),
    .o_next (w_ctr_next)
  );

  // Allocation on a miss overwrites whatever lived at the index.
  assign w_ctr_wr = w_ex_hit   ? w_ctr_next :
                    EX_IS_JUMP ? '1 : LP_WT;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i] <= '0;
        r_tgt[i] <= '0;
        r_ctr[i] <= LP_WNT;
      end
    end else if (w_wr_en) begin
      r_valid[w_ex_idx] <= 1'b1;
      r_tag[w_ex_idx]   <= w_ex_tag;
      r_ctr[w_ex_idx]   <= w_ctr_wr;
      if (w_tgt_wr) r_tgt[w_ex_idx] <= EX_TARGET;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_hits;
  logic [31:0] r_misses;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      if (w_resolve & !w_misp & (r_hits != '1))
        r_hits <= r_hits + 32'd1;
      if (w_misp & (r_misses != '1))
        r_misses <= r_misses + 32'd1;
    end
  end

  assign STAT_HITS   = r_hits;
  assign STAT_MISSES = r_misses;
`else
  assign STAT_HITS   = '0;
  assign STAT_MISSES = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor (default parameters).
// Statistics expectations follow whether BP_STATS_EN is defined.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [11:0] IF_PC;
  logic        PRED_TAKEN;
  logic [11:0] PRED_TARGET;
  logic        EX_VALID;
  logic [11:0] EX_PC;
  logic        EX_IS_BRANCH;
  logic        EX_IS_JUMP;
  logic        EX_TAKEN;
  logic [11:0] EX_TARGET;
  logic        EX_PRED_TAKEN;
  logic [11:0] EX_PRED_TARGET;
  logic        MISPREDICT;
  logic [11:0] REDIRECT_PC;
  logic [31:0] STAT_HITS;
  logic [31:0] STAT_MISSES;

  branch_predictor dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .IF_PC          (IF_PC),
    .PRED_TAKEN     (PRED_TAKEN),
    .PRED_TARGET    (PRED_TARGET),
    .EX_VALID       (EX_VALID),
    .EX_PC          (EX_PC),
    .EX_IS_BRANCH   (EX_IS_BRANCH),
    .EX_IS_JUMP     (EX_IS_JUMP),
    .EX_TAKEN       (EX_TAKEN),
    .EX_TARGET      (EX_TARGET),
    .EX_PRED_TAKEN  (EX_PRED_TAKEN),
    .EX_PRED_TARGET (EX_PRED_TARGET),
    .MISPREDICT     (MISPREDICT),
    .REDIRECT_PC    (REDIRECT_PC),
    .STAT_HITS      (STAT_HITS),
    .STAT_MISSES    (STAT_MISSES)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] ifpc;
    logic        v, br, jp, tk;
    logic [11:0] pc, tgt;
    logic        ptk;
    logic [11:0] ptgt;
    logic        e_pt;
    logic [11:0] e_ptgt;
    logic        e_m;
    logic [11:0] e_rd;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_bad = 0;

`ifdef BP_STATS_EN
  localparam logic [31:0] EXP_H = 32'd3;
  localparam logic [31:0] EXP_M = 32'd2;
`else
  localparam logic [31:0] EXP_H = 32'd0;
  localparam logic [31:0] EXP_M = 32'd0;
`endif

  function automatic vec_t mk(
    input logic [11:0] ifpc,
    input logic v, br, jp, tk,
    input logic [11:0] pc, tgt,
    input logic ptk,
    input logic [11:0] ptgt,
    input logic e_pt,
    input logic [11:0] e_ptgt,
    input logic e_m,
    input logic [11:0] e_rd
  );
    vec_t r;
    r.ifpc = ifpc; r.v = v; r.br = br; r.jp = jp;
    r.tk = tk; r.pc = pc; r.tgt = tgt; r.ptk = ptk;
    r.ptgt = ptgt; r.e_pt = e_pt; r.e_ptgt = e_ptgt;
    r.e_m = e_m; r.e_rd = e_rd;
    return r;
  endfunction

  task automatic drive(
    input logic [11:0] ifpc,
    input logic v, br, jp, tk,
    input logic [11:0] pc, tgt,
    input logic ptk,
    input logic [11:0] ptgt
  );
    IF_PC = ifpc; EX_VALID = v; EX_IS_BRANCH = br;
    EX_IS_JUMP = jp; EX_TAKEN = tk; EX_PC = pc;
    EX_TARGET = tgt; EX_PRED_TAKEN = ptk;
    EX_PRED_TARGET = ptgt;
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  initial begin
    // if   v br jp tk pc     tgt    ptk ptgt | pt ptgt m rd
    tv.push_back(mk(12'h040,0,0,0,0,12'h000,12'h000,0,12'h000, 0,12'h044,0,12'h004));
    tv.push_back(mk(12'h040,1,1,0,1,12'h040,12'h010,0,12'h000, 0,12'h044,1,12'h010));
    tv.push_back(mk(12'h040,0,0,0,0,12'h040,12'h000,0,12'h000, 1,12'h010,0,12'h044));
    tv.push_back(mk(12'h040,1,1,0,0,12'h040,12'h010,1,12'h010, 1,12'h010,1,12'h044));
    tv.push_back(mk(12'h040,0,0,0,0,12'h040,12'h000,0,12'h000, 0,12'h044,0,12'h044));
    tv.push_back(mk(12'h040,1,1,0,0,12'h040,12'h010,0,12'h000, 0,12'h044,0,12'h044));
    tv.push_back(mk(12'h040,1,1,0,0,12'h040,12'h010,0,12'h000, 0,12'h044,0,12'h044));
    tv.push_back(mk(12'h040,1,1,0,1,12'h040,12'h010,0,12'h000, 0,12'h044,1,12'h010));
    tv.push_back(mk(12'h040,1,1,0,1,12'h040,12'h010,0,12'h000, 0,12'h044,1,12'h010));
    tv.push_back(mk(12'h040,0,0,0,0,12'h040,12'h000,0,12'h000, 1,12'h010,0,12'h044));
    tv.push_back(mk(12'h040,1,1,0,1,12'h040,12'h010,1,12'h010, 1,12'h010,0,12'h010));
    tv.push_back(mk(12'h040,1,1,0,1,12'h040,12'h010,1,12'h010, 1,12'h010,0,12'h010));
    tv.push_back(mk(12'h040,1,1,0,0,12'h040,12'h010,1,12'h010, 1,12'h010,1,12'h044));
    tv.push_back(mk(12'h040,0,0,0,0,12'h040,12'h000,0,12'h000, 1,12'h010,0,12'h044));
    tv.push_back(mk(12'h040,1,1,0,1,12'h040,12'h020,1,12'h010, 1,12'h010,1,12'h020));
    tv.push_back(mk(12'h040,0,0,0,0,12'h040,12'h000,0,12'h000, 1,12'h020,0,12'h044));
    tv.push_back(mk(12'h040,1,0,1,1,12'h080,12'h100,0,12'h000, 1,12'h020,1,12'h100));
    tv.push_back(mk(12'h040,0,0,0,0,12'h080,12'h000,0,12'h000, 0,12'h044,0,12'h084));
    tv.push_back(mk(12'h080,0,0,0,0,12'h080,12'h000,0,12'h000, 1,12'h100,0,12'h084));
    tv.push_back(mk(12'h080,1,1,0,0,12'h080,12'h100,1,12'h100, 1,12'h100,1,12'h084));
    tv.push_back(mk(12'h080,0,0,0,0,12'h080,12'h000,0,12'h000, 1,12'h100,0,12'h084));
    tv.push_back(mk(12'h080,1,0,0,0,12'hFFC,12'h000,1,12'h000, 1,12'h100,1,12'h000));
    tv.push_back(mk(12'hFFC,0,0,0,0,12'hFFC,12'h000,0,12'h000, 0,12'h000,0,12'h000));
    tv.push_back(mk(12'h080,0,0,0,0,12'h000,12'h000,0,12'h000, 1,12'h100,0,12'h004));
    tv.push_back(mk(12'h080,0,1,0,1,12'h0C0,12'h200,0,12'h000, 1,12'h100,0,12'h200));
    tv.push_back(mk(12'h0C0,0,0,0,0,12'h0C0,12'h000,0,12'h000, 0,12'h0C4,0,12'h0C4));
    tv.push_back(mk(12'h080,1,0,1,1,12'h080,12'h104,1,12'h100, 1,12'h100,1,12'h104));
    tv.push_back(mk(12'h080,0,0,0,0,12'h080,12'h000,0,12'h000, 1,12'h104,0,12'h084));
    tv.push_back(mk(12'h080,1,1,0,0,12'h080,12'h104,1,12'h104, 1,12'h104,1,12'h084));
    tv.push_back(mk(12'h080,0,0,0,0,12'h080,12'h000,0,12'h000, 1,12'h104,0,12'h084));

    RSTn = 1'b0;
    drive(12'h040,1,0,0,0,12'hFFC,12'h000,1,12'h000);
    repeat (2) @(negedge CLK);
    #1;
    chk("rst pt", 32'(PRED_TAKEN), 32'd0);
    chk("rst ptgt", 32'(PRED_TARGET), 32'h044);
    chk("rst misp", 32'(MISPREDICT), 32'd0);
    chk("rst hits", STAT_HITS, 32'd0);
    chk("rst miss", STAT_MISSES, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge CLK);
      drive(tv[i].ifpc, tv[i].v, tv[i].br, tv[i].jp,
            tv[i].tk, tv[i].pc, tv[i].tgt, tv[i].ptk,
            tv[i].ptgt);
      #1;
      chk($sformatf("v%0d pt", i),
          32'(PRED_TAKEN), 32'(tv[i].e_pt));
      chk($sformatf("v%0d ptgt", i),
          32'(PRED_TARGET), 32'(tv[i].e_ptgt));
      chk($sformatf("v%0d misp", i),
          32'(MISPREDICT), 32'(tv[i].e_m));
      chk($sformatf("v%0d redir", i),
          32'(REDIRECT_PC), 32'(tv[i].e_rd));
    end

    @(negedge CLK);
    RSTn = 1'b0;
    drive(12'h040,0,0,0,0,12'h000,12'h000,0,12'h000);
    @(negedge CLK);
    RSTn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      drive(12'h040,1,1,0,0,12'h200,12'h300,0,12'h000);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      drive(12'h040,1,0,0,0,12'h100,12'h000,1,12'h000);
    end
    @(negedge CLK);
    drive(12'h040,0,0,0,0,12'h000,12'h000,0,12'h000);
    #1;
    chk("stat hits", STAT_HITS, EXP_H);
    chk("stat miss", STAT_MISSES, EXP_M);
    chk("stat tbl", 32'(PRED_TAKEN), 32'd0);

    @(negedge CLK);
    drive(12'h040,1,1,0,1,12'h040,12'h010,0,12'h000);
    @(negedge CLK);
    drive(12'h040,0,0,0,0,12'h000,12'h000,0,12'h000);
    #1;
    chk("learn pt", 32'(PRED_TAKEN), 32'd1);
    chk("learn ptgt", 32'(PRED_TARGET), 32'h010);

    #2;
    RSTn = 1'b0;
    drive(12'h040,1,0,0,0,12'h100,12'h000,1,12'h000);
    #1;
    chk("arst hits", STAT_HITS, 32'd0);
    chk("arst miss", STAT_MISSES, 32'd0);
    chk("arst pt", 32'(PRED_TAKEN), 32'd0);
    chk("arst ptgt", 32'(PRED_TARGET), 32'h044);
    chk("arst misp", 32'(MISPREDICT), 32'd0);
    drive(12'h040,1,1,0,1,12'h0C0,12'h200,0,12'h000);
    @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    drive(12'h0C0,0,0,0,0,12'h000,12'h000,0,12'h000);
    #1;
    chk("norst upd", 32'(PRED_TAKEN), 32'd0);
    chk("norst tgt", 32'(PRED_TARGET), 32'h0C4);
    IF_PC = 12'h040;
    #1;
    chk("discard pt", 32'(PRED_TAKEN), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage RISC-V core. It replaces the static not-taken fetch path and drives the `bpr` bit carried down the pipeline registers. It has two parts:

- a direct-mapped table of saturating counters plus a branch target buffer (BTB), indexed from the fetch PC;
- a resolution port fed from EX, which updates the table and reports mispredicts, with the redirect PC, to the PC mux and the flush logic.

## Interface
Parameters:
- PC_WIDTH, 12, width of byte-addressed PC.
- ENTRIES, 16, table entries; power of 2, at least 2.
- CTR_BITS, 2, saturating-counter width, at least 1.
- IDX_W, derived as log2(ENTRIES). Constraint: PC_WIDTH-2-IDX_W ≥ 1 (tag width TAG_W).

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- IF_PC  in  PC_WIDTH  fetch PC to look up.
- PRED_TAKEN  out  1  predict taken for IF_PC (combinational).
- PRED_TARGET  out  PC_WIDTH  predicted next PC: BTB target if taken, else IF_PC+4.
- EX_VALID  in  1  EX holds a valid, unflushed instruction.
- EX_PC  in  PC_WIDTH  PC of the EX instruction.
- EX_IS_BRANCH  in  1  conditional branch.
- EX_IS_JUMP  in  1  JAL/JALR.
- EX_TAKEN  in  1  resolved direction (1 for jumps).
- EX_TARGET  in  PC_WIDTH  resolved target.
- EX_PRED_TAKEN  in  1  bpr carried with the instruction.
- EX_PRED_TARGET  in  PC_WIDTH  predicted PC carried with the instruction.
- MISPREDICT  out  1  flush IF/ID and ID/EX, redirect fetch (combinational).
- REDIRECT_PC  out  PC_WIDTH  correct next PC.
- STAT_HITS  out  32  correctly predicted resolved control instructions (BP_STATS_EN only).
- STAT_MISSES  out  32  mispredicts (BP_STATS_EN only).

## Operation
- Index is PC[2 +: IDX_W]. Tag is PC[PC_WIDTH-1 : 2+IDX_W].
- Each entry holds: valid, tag, target, and a CTR_BITS counter.
- Lookup is a hit when valid and the tag matches. PRED_TAKEN = hit & counter MSB.
- Resolve event is EX_VALID & (EX_IS_BRANCH | EX_IS_JUMP).
- MISPREDICT = EX_VALID & ((EX_TAKEN & (EX_IS_BRANCH|EX_IS_JUMP)) != EX_PRED_TAKEN | (EX_TAKEN & EX_PRED_TAKEN & EX_TARGET != EX_PRED_TARGET)).
  - A non-control instruction carrying EX_PRED_TAKEN=1 therefore mispredicts.
- REDIRECT_PC is EX_TARGET if the instruction is taken control, else EX_PC+4.
- REDIRECT_PC is a don't-care when MISPREDICT=0, but must still equal that formula.
- Table update at the clock edge on a resolve event, by case:
  - Hit, jump: counter set to max; target written.
  - Hit, branch taken: counter saturating +1; target written.
  - Hit, branch not taken: counter saturating −1; target unchanged.
  - Miss, taken (branch or jump): allocate with valid=1, tag and target written, counter=2^(CTR_BITS−1) (weakly taken; max for jumps). Allocation overwrites any existing entry.
  - Miss, not taken: no change.
- All PC arithmetic (+4) is modulo 2^PC_WIDTH; wrap-around is not an error.
- EX_VALID=0: no update, MISPREDICT=0.

## Timing
- Lookup: 0-cycle, purely combinational from IF_PC and table state.
- Update: visible to lookups from the cycle after the resolving edge.
- Same-cycle lookup and update of one index: the lookup returns the pre-update contents.
- MISPREDICT/REDIRECT_PC: combinational from the EX inputs, same cycle.
- Reset values while RSTn=0, taking effect immediately:
  - all valid=0;
  - counters = 2^(CTR_BITS−1)−1 (weakly not taken);
  - targets = 0;
  - STAT_* = 0.
- Outputs under reset: PRED_TAKEN=0, PRED_TARGET=IF_PC+4, MISPREDICT=0.
- Reset asserted mid-operation discards all learned state. No update occurs on the edge where RSTn is low.

## Configuration
- BP_STATS_EN defined:
  - STAT_HITS increments on every resolve event with MISPREDICT=0.
  - STAT_MISSES increments on every cycle with MISPREDICT=1.
  - Both saturate at 32'hFFFFFFFF.
- BP_STATS_EN undefined: the counters are not built and STAT_HITS/STAT_MISSES are tied to 0.

## Structure
- Shared package bp_pkg holds:
  - counter-state constants (SNT, WNT, WT, ST for CTR_BITS=2);
  - the PC increment constant 4;
  - a function computing weakly-taken/weakly-not-taken values for any CTR_BITS.
- Sub-module bp_sat_counter provides saturating inc/dec/set-max on CTR_BITS, combinational next-value. It is instantiated once, on the write path.

## Test plan
- Reset, then IF_PC=0x040 → PRED_TAKEN=0, PRED_TARGET=0x044; STAT_* = 0.
- Branch at 0x040, target 0x010, resolved taken with EX_PRED_TAKEN=0 → MISPREDICT=1, REDIRECT_PC=0x010. Next cycle, IF_PC=0x040 → PRED_TAKEN=1, PRED_TARGET=0x010.
- Same branch resolved not-taken twice → first resolve gives MISPREDICT=1, REDIRECT_PC=0x044, and the counter goes from 10 to 01. A subsequent lookup predicts not taken. Repeated not-taken resolves saturate the counter at 00.
- Aliasing: allocate 0x040, then resolve taken JAL at 0x080 (same index for ENTRIES=16) → lookup of 0x040 misses (tag mismatch, PRED_TAKEN=0); 0x080 hits with the jump target.
- Non-control instruction with EX_PRED_TAKEN=1 at PC 0xFFC → MISPREDICT=1, REDIRECT_PC=0x000 (wrap). Table unchanged.
- BP_STATS_EN: 3 correct + 2 mispredicted resolves → STAT_HITS=3, STAT_MISSES=2. Asserting RSTn=0 mid-run clears both asynchronously.
